// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;
   localparam logic [3:0] FETCH_BE = 4'hF;
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// mem_rsp_watchdog: clear/enable response counter with terminal count at TIMEOUT-1
module mem_rsp_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign tc = en && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data stages,
// data first, with registered done/rdata pulses and a response watchdog.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t state;
   owner_t owner;
   logic   tc;

   mem_rsp_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state != WAIT_RSP),
      .en    (state == WAIT_RSP),
      .tc    (tc)
   );

   assign if_stall = if_req & ~if_done;
   assign d_stall  = d_req & ~d_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_NONE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               // a requester whose done is pulsing now still shows its old request
               if (d_req && !d_done) begin
                  owner     <= OWN_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_be    <= d_be;
                  state     <= WAIT_GNT;
               end else if (if_req && !if_done) begin
                  owner    <= OWN_I;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
                  mem_be   <= FETCH_BE;
                  state    <= WAIT_GNT;
               end
            end
            WAIT_GNT:
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= WAIT_RSP;
               end
            WAIT_RSP:
               if (mem_rvalid || tc) begin
                  if (owner == OWN_D) begin
                     d_done  <= 1'b1;
                     d_rdata <= mem_rvalid ? mem_rdata : '0;
                  end else begin
                     if_done  <= 1'b1;
                     if_rdata <= mem_rvalid ? mem_rdata : '0;
                  end
                  err   <= ~mem_rvalid;
                  owner <= OWN_NONE;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations, TIMEOUT=4
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done, if_stall;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_rdata;
   logic        d_done, d_stall, err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   int          n_chk = 0;
   int          n_fail = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_rdata   (if_rdata),
      .if_done    (if_done),
      .if_stall   (if_stall),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_rdata    (d_rdata),
      .d_done     (d_done),
      .d_stall    (d_stall),
      .err        (err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // watchdog scenario: load at 0x2008, granted in cycle 1, optional rvalid on the terminal cycle
   task automatic wd_run(input bit tie, input logic [31:0] tie_data);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008; d_be = 4'hF;
      tick();
      check("wd_req", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      tick();
      tick();
      tick();
      check("wd_no_early_done", {31'd0, d_done}, 32'd0);
      if (tie) begin
         mem_rvalid = 1'b1; mem_rdata = tie_data;
      end
      tick();
      mem_rvalid = 1'b0;
      d_req = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_dones", {29'd0, if_done, d_done, err}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // single fetch
      if_req = 1'b1; if_addr = 32'h100;
      settle();
      check("sf_stall_c0", {31'd0, if_stall}, 32'd1);
      tick();
      check("sf_mem_req_c1", {31'd0, mem_req}, 32'd1);
      check("sf_mem_addr", mem_addr, 32'h100);
      check("sf_mem_be_we", {27'd0, mem_be, mem_we}, {27'd0, 4'hF, 1'b0});
      check("sf_stall_c1", {31'd0, if_stall}, 32'd1);
      mem_gnt = 1'b1;
      tick();
      check("sf_mem_req_c2", {31'd0, mem_req}, 32'd0);
      check("sf_stall_c2", {31'd0, if_stall}, 32'd1);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
      tick();
      check("sf_done_c3", {31'd0, if_done}, 32'd1);
      check("sf_rdata", if_rdata, 32'h00500093);
      check("sf_err", {31'd0, err}, 32'd0);
      check("sf_stall_c3", {31'd0, if_stall}, 32'd0);
      mem_rvalid = 1'b0; if_req = 1'b0;
      tick();
      check("sf_done_c4", {31'd0, if_done}, 32'd0);

      // simultaneous: data wins, fetch follows after d_done
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
      tick();
      check("sim_mem_addr_d", mem_addr, 32'h2000);
      check("sim_mem_we", {31'd0, mem_we}, 32'd0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
      tick();
      check("sim_d_done", {30'd0, d_done, if_done}, 32'd2);
      check("sim_d_rdata", d_rdata, 32'h11223344);
      check("sim_no_req_during_done", {31'd0, mem_req}, 32'd0);
      mem_rvalid = 1'b0; d_req = 1'b0;
      tick();
      check("sim_fetch_req", {31'd0, mem_req}, 32'd1);
      check("sim_fetch_addr", mem_addr, 32'h300);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
      tick();
      check("sim_if_done", {31'd0, if_done}, 32'd1);
      check("sim_if_rdata", if_rdata, 32'hAAAA5555);
      mem_rvalid = 1'b0;
      tick();
      check("stale_if_ignored", {31'd0, mem_req}, 32'd0);
      if_req = 1'b0;
      tick();

      // store with grant delayed three cycles
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check($sformatf("st_req_c%0d", c), {31'd0, mem_req}, 32'd1);
         check($sformatf("st_addr_c%0d", c), mem_addr, 32'h2004);
         check($sformatf("st_wdata_c%0d", c), mem_wdata, 32'hDEADBEEF);
         check($sformatf("st_be_we_c%0d", c), {27'd0, mem_be, mem_we}, {27'd0, 4'b0011, 1'b1});
         if (c == 4) mem_gnt = 1'b1;
      end
      tick();
      check("st_req_drop", {31'd0, mem_req}, 32'd0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      settle();
      check("st_stall_before", {31'd0, d_stall}, 32'd1);
      tick();
      check("st_done", {31'd0, d_done}, 32'd1);
      check("st_err", {31'd0, err}, 32'd0);
      check("st_stall_done", {31'd0, d_stall}, 32'd0);
      mem_rvalid = 1'b0; d_req = 1'b0; d_we = 1'b0;
      tick();

      // watchdog expiry, then a late rvalid in IDLE
      wd_run(1'b0, 32'h0);
      check("wd_done", {31'd0, d_done}, 32'd1);
      check("wd_err", {31'd0, err}, 32'd1);
      check("wd_rdata_zero", d_rdata, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      check("wd_late_rvalid", {29'd0, d_done, if_done, err}, 32'd0);
      check("wd_late_no_req", {31'd0, mem_req}, 32'd0);
      tick();

      // rvalid on the terminal cycle wins
      wd_run(1'b1, 32'h0BADC0DE);
      check("tie_done", {31'd0, d_done}, 32'd1);
      check("tie_err", {31'd0, err}, 32'd0);
      check("tie_rdata", d_rdata, 32'h0BADC0DE);
      tick();

      // reset during WAIT_RSP
      if_req = 1'b1; if_addr = 32'h400;
      tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      settle();
      check("mrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("mrst_mem_addr", mem_addr, 32'd0);
      check("mrst_rdata", if_rdata | d_rdata, 32'd0);
      check("mrst_flags", {29'd0, if_done, d_done, err}, 32'd0);
      tick();
      rst_n = 1'b1; if_addr = 32'h500;
      mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
      tick();
      mem_rvalid = 1'b0;
      check("mrst_stale_rvalid", {31'd0, if_done}, 32'd0);
      check("mrst_fresh_req", {31'd0, mem_req}, 32'd1);
      check("mrst_fresh_addr", mem_addr, 32'h500);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
      tick();
      check("mrst_done", {31'd0, if_done}, 32'd1);
      check("mrst_data", if_rdata, 32'h00000013);
      mem_rvalid = 1'b0; if_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the fetch stage and the memory stage of the 5-stage RV32I pipeline.
- Arbitrates between the two requesters and runs a request/grant/response handshake to memory.
- Returns read data with a one-cycle done pulse.
- Drives per-requester stall signals into the hazard controller. A response watchdog counter flags memory that never answers.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT, 64, max cycles in WAIT_RSP before forced completion (must be >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_done.
- if_done  out  1  fetch complete, one-cycle pulse.
- if_stall  out  1  fetch must stall (to StallF logic).
- d_req  in  1  load/store request; held until d_done.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  4  byte enables.
- d_rdata  out  DATA_W  load data; valid while d_done.
- d_done  out  1  data access complete, one-cycle pulse.
- d_stall  out  1  memory stage must stall.
- err  out  1  pulse with a done pulse when completion was forced by the watchdog.
- mem_req  out  1  request to memory.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/4  request fields.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response (reads and writes), exactly one per grant.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- State machine: IDLE, WAIT_GNT, WAIT_RSP. All outputs are registered except the stalls.
- Reset (async, rst_n=0):
  - state=IDLE, owner=NONE, watchdog=0.
  - mem_req=0, mem_we=0, mem_addr/wdata/be=0.
  - if_done=d_done=err=0, if_rdata=d_rdata=0.
- Reset mid-transaction abandons the transaction. Any mem_rvalid arriving after reset release outside WAIT_RSP is dropped.
- IDLE:
  - If d_req and not d_done this cycle: owner=D, latch d_* fields into mem_* registers, go to WAIT_GNT.
  - Else if if_req and not if_done: owner=I, latch if_addr, mem_we=0, mem_be=4'hF, go to WAIT_GNT.
  - Data always has priority; a granted fetch is never preempted.
  - A requester whose done pulses this cycle is ignored this cycle, because its request is stale.
- WAIT_GNT: mem_req=1 with fields stable. On mem_gnt: mem_req<=0, watchdog<=0, go to WAIT_RSP. No timeout in this state.
- WAIT_RSP:
  - Watchdog increments each cycle.
  - On mem_rvalid: the owner's rdata register <= mem_rdata (stores return mem_rdata too, don't-care), owner's done <= 1 next cycle, go to IDLE.
  - Else if watchdog == TIMEOUT-1: owner's done <= 1, err <= 1, owner's rdata <= 0, go to IDLE.
  - If rvalid and timeout coincide, rvalid wins and err=0.
- Done/err pulses last exactly one cycle, the first IDLE cycle after the transaction.
- Minimum latency: request seen in cycle 0 -> mem_req in cycle 1 -> rvalid earliest in cycle 2 -> done in cycle 3.
- Stall outputs are combinational:
  - if_stall = if_req & ~if_done.
  - d_stall = d_req & ~d_done.
- mem_rvalid outside WAIT_RSP is ignored.
- Only one transaction is outstanding at a time. mem_gnt outside WAIT_GNT is ignored.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, WAIT_GNT=2'd1, WAIT_RSP=2'd2.
  - Owner encoding constants: NONE/I/D.
  - Default fetch byte-enable 4'hF.
- One sub-module: mem_rsp_watchdog. It is a clear/enable counter of width $clog2(TIMEOUT) with a terminal-count output.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x100. gnt in cycle 1, rvalid in cycle 2 with rdata=0x00500093.
  - Required: if_done in cycle 3 with if_rdata=0x00500093; if_stall high cycles 0-2, low in cycle 3.
- Simultaneous requests:
  - Stimulus: if_req and d_req (load 0x2000) in the same cycle.
  - Required: data is issued first (mem_addr=0x2000); d_done precedes fetch issue; fetch mem_req follows in the cycle after d_done.
- Store:
  - Stimulus: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011, gnt delayed 3 cycles.
  - Required: mem_req held 4 cycles with stable fields; d_done 1 cycle after rvalid.
- Watchdog:
  - Stimulus: TIMEOUT=4, gnt given, no rvalid.
  - Required: d_done=1, err=1, d_rdata=0 after 4 WAIT_RSP cycles. A late rvalid in IDLE causes no done.
- Boundary tie:
  - Stimulus: rvalid arrives on the watchdog terminal cycle.
  - Required: done with real data, err=0.
- Reset mid-transaction:
  - Stimulus: rst_n low during WAIT_RSP.
  - Required: all outputs 0 immediately. After release, a fresh if_req is issued normally.
